muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes data_rs1/data_rs2 from the register file read ports and produces a write-back (wr_en/addr_rd/data_rd) that drives the register file write port directly.
- Fixed-latency, one operation in flight, start/busy/done handshake toward the decode/control stage.

Parameters:
- REG_WIDTH, 32, operand/result width; the iteration count equals REG_WIDTH.
- REG_ADDR_WIDTH, 5, destination register address width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset_n  input  1  reset, asynchronous, active-low.
- start  input  1  operation request; accepted only when busy=0.
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  REG_WIDTH  rs1 operand (register file data_rs1).
- op_b  input  REG_WIDTH  rs2 operand (register file data_rs2).
- rd_in  input  REG_ADDR_WIDTH  destination register of the request.
- busy  output  1  high from the acceptance edge through the done cycle inclusive.
- done  output  1  one-cycle completion pulse.
- wr_en  output  1  register file write enable (one-cycle pulse).
- addr_rd  output  REG_ADDR_WIDTH  write-back address.
- data_rd  output  REG_WIDTH  write-back data.

Behaviour:
- Reset: state=IDLE, all outputs 0, counter 0, internal accumulators 0. Reset asserted mid-operation aborts it; no write-back occurs afterwards.
- FSM states and transitions:
  - IDLE -> CALC: on posedge with start=1. Latch funct3, rd_in, and operand magnitudes/sign flags; counter=0; busy=1.
  - CALC: one iteration per posedge, counter+1. After the REG_WIDTH-th iteration, go to DONE.
  - DONE: done=1; wr_en=1 unless the latched rd is 0; addr_rd=latched rd; data_rd=result; busy stays 1. Next posedge returns to IDLE, and done, wr_en and busy drop to 0.
- Latency: start sampled at edge N; iterations on edges N+1..N+32; done/wr_en high for exactly the cycle after edge N+33.
- A new start is accepted in IDLE only. A start that is high in the done cycle is ignored; the earliest back-to-back acceptance is the edge after done.
- start is ignored while busy=1; latched operands are unaffected by input changes after acceptance.
- Multiply:
  - Shift-add on unsigned magnitudes into a 2*REG_WIDTH product, then negate if the sign flags differ.
  - Signedness: MUL/MULH signed x signed; MULHSU signed op_a x unsigned op_b; MULHU unsigned x unsigned.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
- Divide:
  - Restoring division on magnitudes.
  - Signed ops: quotient negated if the signs differ; remainder takes the sign of the dividend.
- Divide-by-zero (op_b=0): DIV/DIVU quotient = all ones; REM/REMU = op_a. Latency unchanged, no exception.
- Signed overflow (op_a = 0x80000000, op_b = -1): DIV = 0x80000000, REM = 0. Latency unchanged.
- data_rd and addr_rd hold their last values after done; wr_en is the only qualifier.

Test Plan:
- Reset then MUL op_a=7, op_b=0xFFFFFFFD, rd_in=5 -> busy 1 at N+1, done and wr_en high only in the cycle after edge N+33, addr_rd=5, data_rd=0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same -> 0. All complete in 33 cycles.
- start held high continuously with changing operands during an op -> only the first op executes; its result is unaffected by the input changes; next acceptance is on the edge after done. rd_in=0 -> done pulses, wr_en stays 0.
- reset_n low at iteration 10 -> outputs 0 immediately; after release, no done/wr_en until a new start; a fresh op completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One operation in flight; 32 shift-add or restoring-divide iterations
// followed by a sign-fixup cycle, then a one-cycle write-back pulse.
module muldiv_unit #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [2:0]                funct3,
  input  logic [REG_WIDTH-1:0]      op_a,
  input  logic [REG_WIDTH-1:0]      op_b,
  input  logic [REG_ADDR_WIDTH-1:0] rd_in,
  output logic                      busy,
  output logic                      done,
  output logic                      wr_en,
  output logic [REG_ADDR_WIDTH-1:0] addr_rd,
  output logic [REG_WIDTH-1:0]      data_rd
);

  localparam int CNT_W = $clog2(REG_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REG_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          count;
  logic [2:0]                op;
  logic [REG_ADDR_WIDTH-1:0] rd;
  logic                      neg_a;
  logic                      neg_b;
  logic                      div_zero;
  // Multiply: {acc_hi, acc_lo} is the product, acc_lo starts as the multiplier.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
  logic [REG_WIDTH-1:0]      acc_hi;
  logic [REG_WIDTH-1:0]      acc_lo;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [REG_WIDTH-1:0]      mcand;

  logic                      req_div;
  logic                      req_sign_a;
  logic                      req_sign_b;
  logic                      req_neg_a;
  logic                      req_neg_b;
  logic [REG_WIDTH-1:0]      req_mag_a;
  logic [REG_WIDTH-1:0]      req_mag_b;

  logic [REG_WIDTH:0]        mul_sum;
  logic [REG_WIDTH:0]        div_shift;
  logic [REG_WIDTH:0]        div_diff;
  logic [REG_WIDTH-1:0]      next_hi;
  logic [REG_WIDTH-1:0]      next_lo;

  logic [2*REG_WIDTH-1:0]    prod_signed;
  logic [REG_WIDTH-1:0]      quo_signed;
  logic [REG_WIDTH-1:0]      rem_signed;
  logic [REG_WIDTH-1:0]      result;

  // Decode signedness of the incoming request and take operand magnitudes.
  always_comb begin
    req_div    = funct3[2];
    req_sign_a = req_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
    req_sign_b = req_div ? ~funct3[0] : ~funct3[1];
    req_neg_a  = req_sign_a & op_a[REG_WIDTH-1];
    req_neg_b  = req_sign_b & op_b[REG_WIDTH-1];
    req_mag_a  = req_neg_a ? -op_a : op_a;
    req_mag_b  = req_neg_b ? -op_b : op_b;
  end

  // One shift-add or restoring-divide step on the accumulators.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    div_shift = {acc_hi, acc_lo[REG_WIDTH-1]};
    div_diff  = div_shift - {1'b0, mcand};
    next_hi   = '0;
    next_lo   = '0;
    if (op[2]) begin
      if (!div_diff[REG_WIDTH]) begin
        next_hi = div_diff[REG_WIDTH-1:0];
        next_lo = {acc_lo[REG_WIDTH-2:0], 1'b1};
      end else begin
        next_hi = div_shift[REG_WIDTH-1:0];
        next_lo = {acc_lo[REG_WIDTH-2:0], 1'b0};
      end
    end else begin
      next_hi = mul_sum[REG_WIDTH:1];
      next_lo = {mul_sum[0], acc_lo[REG_WIDTH-1:1]};
    end
  end

  // Re-apply signs and pick the word the operation returns; divide-by-zero
  // quotient is forced to all ones, while the remainder naturally equals op_a.
  always_comb begin
    prod_signed = (neg_a ^ neg_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    quo_signed  = div_zero ? '1 : ((neg_a ^ neg_b) ? -acc_lo : acc_lo);
    rem_signed  = neg_a ? -acc_hi : acc_hi;
    case (op)
      3'b000:                 result = prod_signed[REG_WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result = prod_signed[2*REG_WIDTH-1:REG_WIDTH];
      3'b100, 3'b101:         result = quo_signed;
      default:                result = rem_signed;
    endcase
  end

  // Control FSM with registered handshake and write-back outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      count    <= '0;
      op       <= '0;
      rd       <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_en    <= 1'b0;
      addr_rd  <= '0;
      data_rd  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done  <= 1'b0;
          wr_en <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            state    <= CALC;
            busy     <= 1'b1;
            count    <= '0;
            op       <= funct3;
            rd       <= rd_in;
            neg_a    <= req_neg_a;
            neg_b    <= req_neg_b;
            div_zero <= (op_b == '0);
            acc_hi   <= '0;
            acc_lo   <= req_div ? req_mag_a : req_mag_b;
            mcand    <= req_div ? req_mag_b : req_mag_a;
          end
        end
        CALC: begin
          if (count == LAST) begin
            state   <= DONE;
            done    <= 1'b1;
            wr_en   <= (rd != '0);
            addr_rd <= rd;
            data_rd <= result;
          end else begin
            acc_hi <= next_hi;
            acc_lo <= next_lo;
            count  <= count + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          wr_en <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          wr_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an expected-result queue.
module tb_muldiv_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        wr_en;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wr;
  } exp_t;

  exp_t sb[$];
  int   tests_run;
  int   tests_failed;

  muldiv_unit #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .wr_en   (wr_en),
    .addr_rd (addr_rd),
    .data_rd (data_rd)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Independent reference built on 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sbv, ps;
    logic [63:0] ua, ub, pu;
    logic signed [31:0] qa, qb;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    qa  = a;
    qb  = b;
    case (f)
      3'd0: begin ps = sa * sbv; return ps[31:0]; end
      3'd1: begin ps = sa * sbv; return ps[63:32]; end
      3'd2: begin ps = sa * $signed(ub); return ps[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(qa / qb);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(qa % qb);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  // Drive one request, push its expectation, release start after acceptance
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] expected);
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_in  = rd;
    e.rd   = rd;
    e.data = expected;
    e.wr   = (rd != 5'd0);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_after_accept", busy, 1'b1);
  endtask

  // Wait (bounded) for done, pop the expectation and compare write-back
  task automatic waitResult(input bit scramble);
    exp_t e;
    int   k;
    k = 0;
    while (k < 40 && done !== 1'b1) begin
      @(negedge clk);
      k++;
      if (scramble) begin
        op_a   = $urandom;
        op_b   = $urandom;
        funct3 = 3'($urandom_range(0, 7));
        rd_in  = 5'($urandom_range(0, 31));
      end
    end
    checkOutput("latency", k, 33);
    checkOutput("sb_not_empty", (sb.size() != 0), 1'b1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("wr_en", wr_en, e.wr);
      checkOutput("addr_rd", addr_rd, e.rd);
      checkOutput("data_rd", data_rd, e.data);
    end
    checkOutput("busy_in_done", busy, 1'b1);
    @(negedge clk);
    checkOutput("done_drop", done, 1'b0);
    checkOutput("wr_en_drop", wr_en, 1'b0);
    checkOutput("busy_drop", busy, 1'b0);
  endtask

  task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expected);
    applyStimulus(f, a, b, rd, expected);
    waitResult(1'b0);
  endtask

  initial begin
    exp_t e;
    bit   seen;
    logic [2:0]  rf;
    logic [31:0] ra, rb;
    tests_run    = 0;
    tests_failed = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    funct3  = 3'd0;
    op_a    = 32'd0;
    op_b    = 32'd0;
    rd_in   = 5'd0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_wr_en", wr_en, 1'b0);
    checkOutput("reset_data", data_rd, 32'd0);
    checkOutput("reset_addr", addr_rd, 5'd0);
    reset_n = 1'b1;

    runOp(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
    runOp(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
    runOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    runOp(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    runOp(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF);
    runOp(3'd5, 32'd100, 32'd7, 5'd7, 32'd14);
    runOp(3'd7, 32'd100, 32'd7, 5'd8, 32'd2);
    runOp(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF);
    runOp(3'd7, 32'd5, 32'd0, 5'd10, 32'd5);
    runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000);
    runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0);
    runOp(3'd4, 32'hFFFF_FFF9, 32'd0, 5'd13, 32'hFFFF_FFFF);
    runOp(3'd6, 32'hFFFF_FFF9, 32'd0, 5'd14, 32'hFFFF_FFF9);

    // Random operations against the reference model
    for (int i = 0; i < 6; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 0) ? 32'd3 : $urandom;
      runOp(rf, ra, rb, 5'(i + 16), model(rf, ra, rb));
    end

    // start held high with inputs changing: only the first op runs
    applyStimulus(3'd0, 32'd3, 32'd5, 5'd7, 32'd15);
    start = 1'b1;
    waitResult(1'b1);
    funct3 = 3'd5;
    op_a   = 32'd100;
    op_b   = 32'd7;
    rd_in  = 5'd9;
    e.rd   = 5'd9;
    e.data = 32'd14;
    e.wr   = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_back_to_back", busy, 1'b1);
    waitResult(1'b0);

    // rd = 0 completes but never writes
    runOp(3'd0, 32'd6, 32'd7, 5'd0, 32'd42);

    // Reset in the middle of an operation
    applyStimulus(3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, 32'd0);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_wr_en", wr_en, 1'b0);
    checkOutput("abort_data", data_rd, 32'd0);
    checkOutput("abort_addr", addr_rd, 5'd0);
    void'(sb.pop_back());
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || wr_en === 1'b1) seen = 1'b1;
    end
    checkOutput("no_wb_after_abort", seen, 1'b0);
    runOp(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd21, model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
